// File: rtl/id_ex_ctrl_pipe.sv
// Decode/control stage: combinational opcode decode feeding a registered ID/EX
// control entry, with load-use stall, multi-slot branch flush and EX handshake.
module id_ex_ctrl_pipe #(
  parameter int REG_AW      = 5,
  parameter int IMM_W       = 16,
  parameter int LU_BUBBLES  = 1,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  output logic              id_ready,
  input  logic              br_flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [13:0]       ex_alu_ctrl,
  output logic [1:0]        ex_mem_ctrl,
  output logic [1:0]        ex_br,
  output logic [4:0]        ex_wb_ctrl,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_ra,
  output logic [REG_AW-1:0] ex_rb,
  output logic              hazard_stall,
  output logic              illegal_op
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  typedef struct packed {
    logic              valid;
    logic [13:0]       alu;
    logic [1:0]        mem;
    logic [1:0]        br;
    logic [4:0]        wb;
    logic [IMM_W-1:0]  imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              illegal;
  } entry_t;

  localparam logic [5:0] OP_R   = 6'b010101;
  localparam logic [5:0] OP_LD  = 6'b000001;
  localparam logic [5:0] OP_ST  = 6'b100001;
  localparam logic [5:0] OP_BEQ = 6'b010001;
  localparam logic [5:0] OP_BNE = 6'b110001;
  localparam logic [5:0] OP_NOP = 6'b001111;

  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [1:0] FL_INIT = 2'(FLUSH_SLOTS - 1);

  state_t     state_q, state_d;
  logic [1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  entry_t     ent_q, ent_d;
  entry_t     dec;

  logic [5:0] op;
  logic       regwrite, memread, memwrite, memtoreg, is_nop, is_ill;
  logic [1:0] br;
  logic       use_ra, use_rb, use_rd;
  logic       hz;

  assign op = id_instr[5:0];

  always_comb begin
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    br       = 2'b00;
    is_nop   = 1'b0;
    is_ill   = 1'b0;
    use_ra   = 1'b0;
    use_rb   = 1'b0;
    use_rd   = 1'b0;
    case (op)
      OP_R:   begin regwrite = 1'b1; use_ra = 1'b1; use_rb = 1'b1; end
      OP_LD:  begin regwrite = 1'b1; memread = 1'b1; memtoreg = 1'b1; use_ra = 1'b1; end
      OP_ST:  begin memwrite = 1'b1; use_ra = 1'b1; use_rd = 1'b1; end
      OP_BEQ: begin br = 2'b01; use_ra = 1'b1; use_rb = 1'b1; end
      OP_BNE: begin br = 2'b10; use_ra = 1'b1; use_rb = 1'b1; end
      OP_NOP: is_nop = 1'b1;
      default: is_ill = 1'b1;
    endcase

    dec         = '0;
    dec.valid   = 1'b1;
    dec.rb      = id_instr[6 +: REG_AW];
    dec.ra      = id_instr[6 + REG_AW +: REG_AW];
    dec.rd      = id_instr[6 + 2*REG_AW +: REG_AW];
    dec.imm     = IMM_W'(id_instr[31:21]);
    dec.mem     = {memread, memwrite};
    dec.br      = br;
    dec.illegal = is_ill;
    // nop and undefined opcodes carry no ALU/writeback control at all
    dec.alu     = (is_nop || is_ill) ? 14'd0 : {op, id_instr[25:24], id_instr[31:26]};
    dec.wb      = {(is_nop || is_ill) ? 3'd0 : id_instr[23:21], memtoreg, regwrite};
  end

  // Load-use: the load still sitting in ID/EX writes a register this instruction reads
  assign hz = (state_q == RUN) && id_valid && ent_q.valid && ent_q.mem[1] &&
              ((use_ra && (ent_q.rd == dec.ra)) ||
               (use_rb && (ent_q.rd == dec.rb)) ||
               (use_rd && (ent_q.rd == dec.rd)));

  assign id_ready     = !rst && (br_flush || (ex_ready && (state_q != STALL) && !hz));
  assign hazard_stall = !rst && !br_flush && ((state_q == STALL) || hz);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ent_d       = ent_q;
    if (br_flush) begin
      // flush bookkeeping proceeds even while EX back-pressures; only the entry holds
      stall_cnt_d = 2'd0;
      flush_cnt_d = FL_INIT;
      state_d     = (FL_INIT != 2'd0) ? FLUSH : RUN;
      if (ex_ready) ent_d = '0;
    end else if (ex_ready) begin
      case (state_q)
        RUN: begin
          if (hz) begin
            ent_d       = '0;
            stall_cnt_d = LU_INIT;
            state_d     = (LU_INIT != 2'd0) ? STALL : RUN;
          end else begin
            ent_d = id_valid ? dec : '0;
          end
        end
        STALL: begin
          ent_d       = '0;
          stall_cnt_d = stall_cnt_q - 2'd1;
          if (stall_cnt_q <= 2'd1) begin
            stall_cnt_d = 2'd0;
            state_d     = RUN;
          end
        end
        FLUSH: begin
          ent_d = '0;
          if (id_valid) begin
            flush_cnt_d = flush_cnt_q - 2'd1;
            if (flush_cnt_q <= 2'd1) begin
              flush_cnt_d = 2'd0;
              state_d     = RUN;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= 2'd0;
      flush_cnt_q <= 2'd0;
      ent_q       <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ent_q       <= ent_d;
    end
  end

  assign ex_valid    = ent_q.valid;
  assign ex_alu_ctrl = ent_q.alu;
  assign ex_mem_ctrl = ent_q.mem;
  assign ex_br       = ent_q.br;
  assign ex_wb_ctrl  = ent_q.wb;
  assign ex_imm      = ent_q.imm;
  assign ex_rd       = ent_q.rd;
  assign ex_ra       = ent_q.ra;
  assign ex_rb       = ent_q.rb;
  assign illegal_op  = ent_q.illegal;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: directed scenarios then randomized traffic, all
// compared each cycle against an instruction-level reference model.
module tb_id_ex_ctrl_pipe;

  localparam int LU_B = 2;
  localparam int FL_S = 2;

  localparam logic [5:0] OP_R   = 6'b010101;
  localparam logic [5:0] OP_LD  = 6'b000001;
  localparam logic [5:0] OP_ST  = 6'b100001;
  localparam logic [5:0] OP_BEQ = 6'b010001;
  localparam logic [5:0] OP_BNE = 6'b110001;
  localparam logic [5:0] OP_NOP = 6'b001111;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_BEQ = 3, K_BNE = 4, K_NOP = 5, K_ILL = 6;

  typedef struct packed {
    logic        v;
    logic [13:0] alu;
    logic [1:0]  mem;
    logic [1:0]  br;
    logic [4:0]  wb;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, br_flush, ex_ready;
  logic [31:0] id_instr;
  logic        id_ready, ex_valid, hazard_stall, illegal_op;
  logic [13:0] ex_alu_ctrl;
  logic [1:0]  ex_mem_ctrl, ex_br;
  logic [4:0]  ex_wb_ctrl;
  logic [15:0] ex_imm;
  logic [4:0]  ex_rd, ex_ra, ex_rb;

  int checks = 0;
  int errors = 0;

  ent_t m;
  int   m_bub, m_disc;
  logic m_hz, exp_idr, exp_hs, obs_idr, obs_hs, last_xfer;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(.REG_AW(5), .IMM_W(16), .LU_BUBBLES(LU_B), .FLUSH_SLOTS(FL_S)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
    .br_flush(br_flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_mem_ctrl(ex_mem_ctrl), .ex_br(ex_br), .ex_wb_ctrl(ex_wb_ctrl), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_ra(ex_ra), .ex_rb(ex_rb), .hazard_stall(hazard_stall),
    .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic [10:0] imm);
    return {imm, rd, ra, rb, op};
  endfunction

  function automatic int kind(input logic [5:0] op);
    case (op)
      OP_R:    return K_R;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_BEQ:  return K_BEQ;
      OP_BNE:  return K_BNE;
      OP_NOP:  return K_NOP;
      default: return K_ILL;
    endcase
  endfunction

  // Expected ID/EX contents for one accepted instruction, straight from the field map
  function automatic ent_t decode(input logic [31:0] ins);
    ent_t e;
    int   k;
    k      = kind(ins[5:0]);
    e      = '0;
    e.v    = 1'b1;
    e.rd   = ins[20:16];
    e.ra   = ins[15:11];
    e.rb   = ins[10:6];
    e.imm  = {5'd0, ins[31:21]};
    if (k <= K_BNE) begin
      e.alu     = {ins[5:0], ins[25:24], ins[31:26]};
      e.wb[4:2] = ins[23:21];
    end
    e.wb[1] = (k == K_LD);
    e.wb[0] = (k == K_R) || (k == K_LD);
    e.mem   = {k == K_LD, k == K_ST};
    e.br    = (k == K_BEQ) ? 2'b01 : (k == K_BNE) ? 2'b10 : 2'b00;
    e.ill   = (k == K_ILL);
    return e;
  endfunction

  function automatic bit src_hit(input logic [31:0] ins, input logic [4:0] r);
    case (kind(ins[5:0]))
      K_R, K_BEQ, K_BNE: return (ins[15:11] == r) || (ins[10:6] == r);
      K_ST:              return (ins[15:11] == r) || (ins[20:16] == r);
      K_LD:              return (ins[15:11] == r);
      default:           return 1'b0;
    endcase
  endfunction

  // One clock: drive inputs, check handshake outputs, advance model, check ID/EX
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic er, input logic r);
    id_valid = v; id_instr = ins; br_flush = fl; ex_ready = er; rst = r;
    #1;
    m_hz    = (m_bub == 0) && (m_disc == 0) && v && m.v && m.mem[1] && src_hit(ins, m.rd);
    exp_idr = !r && (fl || (er && (m_bub == 0) && !m_hz));
    exp_hs  = !r && !fl && ((m_bub > 0) || m_hz);
    obs_idr = id_ready;
    obs_hs  = hazard_stall;
    chk("id_ready", 32'(obs_idr), 32'(exp_idr));
    chk("hazard_stall", 32'(obs_hs), 32'(exp_hs));
    last_xfer = v && exp_idr;
    if (r) begin
      m = '0; m_bub = 0; m_disc = 0;
    end else if (fl) begin
      m_bub = 0; m_disc = FL_S - 1;
      if (er) m = '0;
    end else if (er) begin
      if (m_bub > 0) begin
        m = '0; m_bub--;
      end else if (m_disc > 0) begin
        m = '0;
        if (v) m_disc--;
      end else if (m_hz) begin
        m = '0; m_bub = LU_B - 1;
      end else begin
        m = v ? decode(ins) : '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("ex_valid",    32'(ex_valid),    32'(m.v));
    chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m.alu));
    chk("ex_mem_ctrl", 32'(ex_mem_ctrl), 32'(m.mem));
    chk("ex_br",       32'(ex_br),       32'(m.br));
    chk("ex_wb_ctrl",  32'(ex_wb_ctrl),  32'(m.wb));
    chk("ex_imm",      32'(ex_imm),      32'(m.imm));
    chk("ex_rd",       32'(ex_rd),       32'(m.rd));
    chk("ex_ra",       32'(ex_ra),       32'(m.ra));
    chk("ex_rb",       32'(ex_rb),       32'(m.rb));
    chk("illegal_op",  32'(illegal_op),  32'(m.ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = OP_R;
      1: op = OP_LD;
      2: op = OP_ST;
      3: op = OP_BEQ;
      4: op = OP_BNE;
      5: op = OP_NOP;
      default: op = 6'($urandom_range(0, 1) == 0 ? 6'h3f : 6'h02);
    endcase
    return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom));
  endfunction

  initial begin
    logic [31:0] r7, st7, ins_a, ins_e, cur_i;
    logic        cur_v;
    m = '0; m_bub = 0; m_disc = 0;
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; br_flush = 1'b0; ex_ready = 1'b1;
    @(negedge clk);

    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hffff_ffff, 1'b0, 1'b1, 1'b1);
    chk("rst_idr", 32'(obs_idr), 32'd0);
    chk("rst_valid", 32'(ex_valid), 32'd0);

    step(1'b1, mk(OP_R, 5'd5, 5'd3, 5'd4, 11'h123), 1'b0, 1'b1, 1'b0);
    chk("rtype_valid", 32'(ex_valid), 32'd1);
    chk("rtype_wb", 32'(ex_wb_ctrl[1:0]), 32'd1);
    chk("rtype_mem", 32'(ex_mem_ctrl), 32'd0);
    chk("rtype_rd", 32'(ex_rd), 32'd5);

    step(1'b1, mk(OP_LD, 5'd7, 5'd1, 5'd2, 11'd0), 1'b0, 1'b1, 1'b0);
    r7 = mk(OP_R, 5'd9, 5'd7, 5'd2, 11'd0);
    step(1'b1, r7, 1'b0, 1'b1, 1'b0);
    chk("lu_hs1", 32'(obs_hs), 32'd1);
    chk("lu_rdy1", 32'(obs_idr), 32'd0);
    step(1'b1, r7, 1'b0, 1'b1, 1'b0);
    chk("lu_hs2", 32'(obs_hs), 32'd1);
    chk("lu_rdy2", 32'(obs_idr), 32'd0);
    step(1'b1, r7, 1'b0, 1'b1, 1'b0);
    chk("lu_hs3", 32'(obs_hs), 32'd0);
    chk("lu_issue_valid", 32'(ex_valid), 32'd1);
    chk("lu_issue_rd", 32'(ex_rd), 32'd9);

    step(1'b1, mk(OP_LD, 5'd7, 5'd1, 5'd2, 11'd0), 1'b0, 1'b1, 1'b0);
    st7 = mk(OP_ST, 5'd7, 5'd1, 5'd2, 11'd0);
    step(1'b1, st7, 1'b0, 1'b1, 1'b0);
    chk("st_hazard", 32'(obs_hs), 32'd1);
    step(1'b1, st7, 1'b0, 1'b1, 1'b0);
    step(1'b1, st7, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk(OP_LD, 5'd7, 5'd1, 5'd2, 11'd0), 1'b0, 1'b1, 1'b0);
    step(1'b1, mk(OP_NOP, 5'd7, 5'd7, 5'd7, 11'd0), 1'b0, 1'b1, 1'b0);
    chk("nop_no_hs", 32'(obs_hs), 32'd0);
    chk("nop_valid", 32'(ex_valid), 32'd1);

    ins_a = mk(OP_R, 5'd10, 5'd1, 5'd1, 11'd0);
    step(1'b1, ins_a, 1'b1, 1'b1, 1'b0);
    chk("fl_rdy", 32'(obs_idr), 32'd1);
    chk("fl_slot1", 32'(ex_valid), 32'd0);
    step(1'b1, mk(OP_R, 5'd11, 5'd1, 5'd1, 11'd0), 1'b0, 1'b1, 1'b0);
    chk("fl_slot2", 32'(ex_valid), 32'd0);
    step(1'b1, mk(OP_R, 5'd12, 5'd1, 5'd1, 11'd0), 1'b0, 1'b1, 1'b0);
    chk("fl_third_valid", 32'(ex_valid), 32'd1);
    chk("fl_third_rd", 32'(ex_rd), 32'd12);

    step(1'b1, mk(OP_R, 5'd13, 5'd1, 5'd1, 11'd0), 1'b0, 1'b1, 1'b0);
    ins_e = mk(OP_R, 5'd14, 5'd1, 5'd1, 11'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ins_e, 1'b0, 1'b0, 1'b0);
      chk("hold_rdy", 32'(obs_idr), 32'd0);
      chk("hold_rd", 32'(ex_rd), 32'd13);
    end
    step(1'b1, ins_e, 1'b0, 1'b1, 1'b0);
    chk("release_rd", 32'(ex_rd), 32'd14);
    step(1'b1, mk(OP_R, 5'd15, 5'd1, 5'd1, 11'd0), 1'b0, 1'b1, 1'b0);
    chk("release_next_rd", 32'(ex_rd), 32'd15);

    step(1'b1, mk(6'h3f, 5'd1, 5'd2, 5'd3, 11'h7ff), 1'b0, 1'b1, 1'b0);
    chk("ill_valid", 32'(ex_valid), 32'd1);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_ctrl", 32'({ex_alu_ctrl, ex_mem_ctrl, ex_br, ex_wb_ctrl}), 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("ill_clear", 32'(illegal_op), 32'd0);

    step(1'b1, mk(OP_LD, 5'd7, 5'd1, 5'd2, 11'd0), 1'b0, 1'b1, 1'b0);
    step(1'b1, r7, 1'b0, 1'b1, 1'b0);
    step(1'b1, r7, 1'b0, 1'b1, 1'b1);
    chk("rst_stall_idr", 32'(obs_idr), 32'd0);
    chk("rst_stall_valid", 32'(ex_valid), 32'd0);
    step(1'b1, r7, 1'b0, 1'b1, 1'b0);
    chk("rst_stall_hs", 32'(obs_hs), 32'd0);
    chk("rst_stall_issue", 32'(ex_rd), 32'd9);

    cur_v = 1'b1;
    cur_i = rand_instr();
    for (int n = 0; n < 3000; n++) begin
      step(cur_v, cur_i, $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 299) == 0);
      if (!cur_v || last_xfer) begin
        cur_v = $urandom_range(0, 9) < 8;
        cur_i = rand_instr();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
